// File: rtl/tx_ack_responder_if.sv
// Transmit/acknowledge bundle between transmitter (master) and responder (slave).
// Carries the request, the registered ack/payload return and the responder statistics.
interface tx_ack_responder_if #(
  parameter int DELAY = 2,
  parameter int DW    = 8,
  parameter int CW    = 16
);
  localparam int IW = $clog2(DELAY + 1);

  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          resp_en;
  logic          rx_ack;
  logic [DW-1:0] rx_data;
  logic          miss;
  logic [IW-1:0] in_flight;
  logic [CW-1:0] req_cnt;
  logic [CW-1:0] ack_cnt;

  modport master (
    output tx_valid, tx_data, resp_en,
    input  rx_ack, rx_data, miss, in_flight, req_cnt, ack_cnt
  );

  modport slave (
    input  tx_valid, tx_data, resp_en,
    output rx_ack, rx_data, miss, in_flight, req_cnt, ack_cnt
  );
endinterface

// File: rtl/tx_ack_responder.sv
// Fixed-latency responder: every accepted request is acked exactly DELAY edges later with its payload.
// One request per cycle, no backpressure; requests arriving with resp_en low are dropped and flagged on miss.
module tx_ack_responder #(
  parameter int DELAY = 2,
  parameter int DW    = 8,
  parameter int CW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  tx_ack_responder_if.slave bus
);
  localparam int IW = $clog2(DELAY + 1);

  logic [DELAY-1:0]         vld_q, vld_d;
  logic [DELAY-1:0][DW-1:0] dat_q, dat_d;
  logic                     miss_q, miss_d;
  logic [IW-1:0]            in_flight_q, in_flight_d;
  logic [CW-1:0]            req_cnt_q, req_cnt_d;
  logic [CW-1:0]            ack_cnt_q, ack_cnt_d;
  logic                     accept;
  logic                     ack;

  always_comb begin
    accept = bus.tx_valid & bus.resp_en;
    ack    = vld_q[DELAY-1];

    vld_d[0] = accept;
    for (int i = 1; i < DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // Payload only moves behind a valid bit; empty slots keep stale data to avoid toggling.
    dat_d = dat_q;
    if (accept) begin
      dat_d[0] = bus.tx_data;
    end
    for (int i = 1; i < DELAY; i++) begin
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end

    miss_d = bus.tx_valid & ~bus.resp_en;

    in_flight_d = in_flight_q;
    if (accept && !ack) begin
      in_flight_d = in_flight_q + IW'(1);
    end else if (!accept && ack) begin
      in_flight_d = in_flight_q - IW'(1);
    end

    req_cnt_d = req_cnt_q;
    if (accept && (req_cnt_q != {CW{1'b1}})) begin
      req_cnt_d = req_cnt_q + CW'(1);
    end

    ack_cnt_d = ack_cnt_q;
    if (ack && (ack_cnt_q != {CW{1'b1}})) begin
      ack_cnt_d = ack_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      dat_q       <= '0;
      miss_q      <= 1'b0;
      in_flight_q <= '0;
      req_cnt_q   <= '0;
      ack_cnt_q   <= '0;
    end else begin
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      miss_q      <= miss_d;
      in_flight_q <= in_flight_d;
      req_cnt_q   <= req_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
    end
  end

  assign bus.rx_ack    = vld_q[DELAY-1];
  assign bus.rx_data   = dat_q[DELAY-1];
  assign bus.miss      = miss_q;
  assign bus.in_flight = in_flight_q;
  assign bus.req_cnt   = req_cnt_q;
  assign bus.ack_cnt   = ack_cnt_q;
endmodule
